ldtu_baseline_flag_gen: RTL and testbench
=========================================

Name: ldtu_baseline_flag_gen

Overview:
Pre-stage of the LiTe-DTU compression FSM. Per 12-bit ADC sample (plus gain bit) it decides whether the sample fits the 6-bit baseline encoding and produces baseline_flag. It turns the raw BC0 level into single-cycle orbit pulses, routed to either the standard or the fallback FSM. It delays sample, flag and orbit by a fixed latency so all three reach the FSM and the downstream encoder in the same cycle.

Parameters:
Nbits, 12, ADC sample width (gain bit sits above it)
DELAY, 2, pipeline latency in CLK cycles from DATA_in/BC0_in to outputs; legal 1..8
ORBIT_LEN, 3564, expected BC0 spacing in CLK cycles (used only by the optional feature)

Ports:
CLK  in  1  LiTe-DTU clock
rst_b  in  1  asynchronous active-low reset
fallback  in  1  1 = fallback mode (no compression)
DATA_in  in  Nbits+1  [Nbits] = gain select (1 = x1 gain), [Nbits-1:0] = sample
BC0_in  in  1  bunch-crossing-zero level; may stay high for several cycles
bsl_limit  in  7  baseline threshold; quasi-static; values above 64 are treated as 64
DATA_out  out  Nbits+1  DATA_in delayed by DELAY
baseline_flag  out  1  aligned with DATA_out
Orbit  out  1  orbit pulse for the standard FSM
Orbit_FB  out  1  orbit pulse for the fallback FSM

Behaviour:
- All flops reset asynchronously on rst_b=0. During and after reset: DATA_out=0, baseline_flag=0, Orbit=0, Orbit_FB=0, all delay stages cleared. No clock is needed for reset to take effect.
- Stage 1 registers DATA_in and computes the flag:
  - flag = (DATA_in[Nbits]==0) && (DATA_in[Nbits-1:0] < min(bsl_limit,64)).
  - The compare is unsigned and zero-extended to Nbits.
  - bsl_limit=0 forces flag=0.
- Stages 2..DELAY form a plain shift line. Each stage carries {data, flag, orbit_pulse}. Total latency is exactly DELAY cycles. With DELAY=1 the stage-1 registers drive the outputs.
- Orbit edge detect:
  - A bc0_q register samples BC0_in.
  - pulse = BC0_in && !bc0_q, so a level held N cycles gives one pulse.
  - bc0_q resets to 1, so a BC0_in level already high at reset release produces no pulse until it falls and rises again.
  - The pulse enters stage 1 in the same cycle as the coincident sample.
- Output routing uses the registered fallback value at the final stage:
  - Orbit = pulse && !fallback_q.
  - Orbit_FB = pulse && fallback_q.
  - Never both high in the same cycle.
- A fallback toggle mid-pipeline affects only routing of pulses leaving after the toggle. Data and flag keep flowing unchanged. No flush.
- Back-to-back BC0 edges, with BC0_in alternating every cycle, give a pulse every second cycle. No merging or loss.
- A reset mid-stream discards every in-flight sample and pulse. Outputs return to 0 asynchronously.
- No handshake: one sample per CLK, always accepted.

Optional Feature:
Macro LDTU_ORBIT_CHECK_EN.
- When defined:
  - Adds a 12-bit cycle counter `orb_cnt`, reset to 0. It clears on each detected edge and otherwise increments, saturating at 4095.
  - Adds output `orbit_err` (1 bit, sticky, reset 0). It sets when an edge arrives and all of the following hold:
    - at least one earlier edge has been seen since reset;
    - orb_cnt != ORBIT_LEN-1.
  - orbit_err clears only on rst_b.
  - Adds output `orbit_cnt_o` [15:0]: count of detected edges, wrapping at 65535.
- When not defined: the counters and both ports are absent. Behaviour is otherwise identical.

Test Plan:
- Reset check: rst_b=0 with random inputs toggling → all outputs 0. Release rst_b → DATA_out follows DATA_in exactly DELAY=2 cycles later.
- Threshold boundaries, bsl_limit=64:
  - DATA_in 0x003F → baseline_flag=1
  - 0x0040 → 0
  - 0x1005 (gain=1) → 0
- bsl_limit=100 behaves as 64 (0x003F→1, 0x0040→0). bsl_limit=0 with 0x0000 → flag 0.
- Orbit pulse: BC0_in high for 5 cycles with fallback=0 → exactly one Orbit pulse, 2 cycles after the rising edge, coincident with that cycle's sample. Orbit_FB stays 0.
- Fallback routing: fallback=1 and BC0 edges 10 cycles apart → Orbit_FB pulses only. Toggling fallback to 0 between edges → the next pulse appears on Orbit.
- With LDTU_ORBIT_CHECK_EN and ORBIT_LEN=16:
  - Edges 16 cycles apart → orbit_err stays 0 and orbit_cnt_o increments.
  - One 15-cycle gap → orbit_err=1, and it stays set until rst_b.

Source files
------------

// File: rtl/ldtu_baseline_flag_gen_if.sv
// ============================================================================
// Module : ldtu_baseline_flag_gen_if
// Brief  : Sample/orbit bus for the LiTe-DTU baseline-flag pre-stage.
//          Optional orbit-check signals present with LDTU_ORBIT_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ldtu_baseline_flag_gen_if #(
  parameter int NBITS = 12
);
  logic             fallback;
  logic [NBITS:0]   DATA_in;
  logic             BC0_in;
  logic [6:0]       bsl_limit;
  logic [NBITS:0]   DATA_out;
  logic             baseline_flag;
  logic             Orbit;
  logic             Orbit_FB;
`ifdef LDTU_ORBIT_CHECK_EN
  logic             orbit_err;
  logic [15:0]      orbit_cnt_o;

  modport master (
    output fallback, DATA_in, BC0_in, bsl_limit,
    input  DATA_out, baseline_flag, Orbit, Orbit_FB, orbit_err, orbit_cnt_o
  );
  modport slave (
    input  fallback, DATA_in, BC0_in, bsl_limit,
    output DATA_out, baseline_flag, Orbit, Orbit_FB, orbit_err, orbit_cnt_o
  );
`else
  modport master (
    output fallback, DATA_in, BC0_in, bsl_limit,
    input  DATA_out, baseline_flag, Orbit, Orbit_FB
  );
  modport slave (
    input  fallback, DATA_in, BC0_in, bsl_limit,
    output DATA_out, baseline_flag, Orbit, Orbit_FB
  );
`endif
endinterface

`default_nettype wire

// File: rtl/ldtu_baseline_flag_gen.sv
// ============================================================================
// Module : ldtu_baseline_flag_gen
// Brief  : Baseline-flag, orbit-pulse and alignment pipeline ahead of the
//          compression FSM. Optional orbit spacing check: LDTU_ORBIT_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ldtu_baseline_flag_gen #(
  parameter int NBITS     = 12,
  parameter int DELAY     = 2,
  parameter int ORBIT_LEN = 3564
) (
  input  wire logic                  CLK,
  input  wire logic                  rst_b,
  ldtu_baseline_flag_gen_if.slave    bus
);

  localparam logic [6:0] c_LIMIT_MAX = 7'd64;

  logic [6:0]                 w_limit;
  logic [NBITS-1:0]           w_limit_ext;
  logic                       w_flag;
  logic                       w_pulse;

  logic                       r_bc0_q;
  logic                       r_fb_q;
  logic [DELAY-1:0][NBITS:0]  r_data;
  logic [DELAY-1:0]           r_flag;
  logic [DELAY-1:0]           r_pulse;

  assign w_limit     = (bus.bsl_limit > c_LIMIT_MAX) ? c_LIMIT_MAX : bus.bsl_limit;
  assign w_limit_ext = {{(NBITS-7){1'b0}}, w_limit};
  assign w_flag      = ~bus.DATA_in[NBITS] && (bus.DATA_in[NBITS-1:0] < w_limit_ext);
  // bc0_q resets high so a BC0 level already asserted at release is not an edge.
  assign w_pulse     = bus.BC0_in & ~r_bc0_q;

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_bc0_q <= 1'b1;
      r_fb_q  <= 1'b0;
      r_data  <= '0;
      r_flag  <= '0;
      r_pulse <= '0;
    end else begin
      r_bc0_q    <= bus.BC0_in;
      r_fb_q     <= bus.fallback;
      r_data[0]  <= bus.DATA_in;
      r_flag[0]  <= w_flag;
      r_pulse[0] <= w_pulse;
      for (int i = 1; i < DELAY; i++) begin
        r_data[i]  <= r_data[i-1];
        r_flag[i]  <= r_flag[i-1];
        r_pulse[i] <= r_pulse[i-1];
      end
    end
  end

  assign bus.DATA_out      = r_data[DELAY-1];
  assign bus.baseline_flag = r_flag[DELAY-1];
  assign bus.Orbit         = r_pulse[DELAY-1] & ~r_fb_q;
  assign bus.Orbit_FB      = r_pulse[DELAY-1] &  r_fb_q;

`ifdef LDTU_ORBIT_CHECK_EN
  localparam logic [11:0] c_ORB_LAST = 12'(ORBIT_LEN - 1);

  logic [11:0] r_orb_cnt;
  logic        r_seen;
  logic        r_orbit_err;
  logic [15:0] r_edge_cnt;

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_orb_cnt   <= '0;
      r_seen      <= 1'b0;
      r_orbit_err <= 1'b0;
      r_edge_cnt  <= '0;
    end else if (w_pulse) begin
      if (r_seen && (r_orb_cnt != c_ORB_LAST)) begin
        r_orbit_err <= 1'b1;
      end
      r_seen     <= 1'b1;
      r_orb_cnt  <= '0;
      r_edge_cnt <= r_edge_cnt + 16'd1;
    end else if (r_orb_cnt != 12'hFFF) begin
      r_orb_cnt <= r_orb_cnt + 12'd1;
    end
  end

  assign bus.orbit_err   = r_orbit_err;
  assign bus.orbit_cnt_o = r_edge_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ldtu_baseline_flag_gen.sv
// ============================================================================
// Module : tb_ldtu_baseline_flag_gen
// Brief  : Scoreboard bench for ldtu_baseline_flag_gen (DELAY=2, ORBIT_LEN=16).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ldtu_baseline_flag_gen;

  localparam int NBITS     = 12;
  localparam int DELAY     = 2;
  localparam int ORBIT_LEN = 16;

  logic CLK   = 1'b0;
  logic rst_b = 1'b1;

  always #5 CLK = ~CLK;

  ldtu_baseline_flag_gen_if #(.NBITS(NBITS)) bus ();

  ldtu_baseline_flag_gen #(
    .NBITS     (NBITS),
    .DELAY     (DELAY),
    .ORBIT_LEN (ORBIT_LEN)
  ) dut (
    .CLK   (CLK),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Each entry: {data, flag, pulse}
  logic [NBITS+2:0] sb_q[$];
  logic             m_bc0_q;
  logic             m_fb_q;
`ifdef LDTU_ORBIT_CHECK_EN
  logic [11:0]      m_cnt;
  logic             m_seen;
  logic             m_err;
  logic [15:0]      m_edges;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic flag_of(input logic [NBITS:0] d, input logic [6:0] lim);
    logic [6:0] l;
    l = (lim > 7'd64) ? 7'd64 : lim;
    return !d[NBITS] && (d[NBITS-1:0] < {5'b0, l});
  endfunction

  function automatic logic [NBITS:0] rnd_data();
    return 13'($urandom_range(0, 8191));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},   32'(bus.DATA_out),      32'd0);
    chk({tag, "_flag"},   32'(bus.baseline_flag), 32'd0);
    chk({tag, "_orbit"},  32'(bus.Orbit),         32'd0);
    chk({tag, "_orbfb"},  32'(bus.Orbit_FB),      32'd0);
`ifdef LDTU_ORBIT_CHECK_EN
    chk({tag, "_err"},    32'(bus.orbit_err),     32'd0);
    chk({tag, "_ocnt"},   32'(bus.orbit_cnt_o),   32'd0);
`endif
  endtask

  // Compare current outputs against the oldest expectation, then drive a new sample.
  task automatic step(input logic [NBITS:0] d, input logic bc0, input logic fb);
    logic [NBITS+2:0] e;
    logic             p;
    e = sb_q.pop_front();
    chk("data",     32'(bus.DATA_out),      32'(e[NBITS+2:2]));
    chk("flag",     32'(bus.baseline_flag), 32'(e[1]));
    chk("orbit",    32'(bus.Orbit),         32'(e[0] & ~m_fb_q));
    chk("orbit_fb", 32'(bus.Orbit_FB),      32'(e[0] &  m_fb_q));
`ifdef LDTU_ORBIT_CHECK_EN
    chk("orbit_err", 32'(bus.orbit_err),   32'(m_err));
    chk("orbit_cnt", 32'(bus.orbit_cnt_o), 32'(m_edges));
`endif
    bus.DATA_in  = d;
    bus.BC0_in   = bc0;
    bus.fallback = fb;
    p       = bc0 & ~m_bc0_q;
    m_bc0_q = bc0;
    m_fb_q  = fb;
    sb_q.push_back({d, flag_of(d, bus.bsl_limit), p});
`ifdef LDTU_ORBIT_CHECK_EN
    if (p) begin
      if (m_seen && (m_cnt != 12'(ORBIT_LEN - 1))) m_err = 1'b1;
      m_seen  = 1'b1;
      m_cnt   = '0;
      m_edges = m_edges + 16'd1;
    end else if (m_cnt != 12'hFFF) begin
      m_cnt = m_cnt + 12'd1;
    end
`endif
    @(negedge CLK);
  endtask

  // Assert reset mid-cycle, verify asynchronous clearing, then release at a negedge.
  task automatic apply_reset();
    #2 rst_b = 1'b0;
    #1 chk_zero("rst_async");
    repeat (3) begin
      bus.DATA_in  = rnd_data();
      bus.BC0_in   = rnd_bit();
      bus.fallback = rnd_bit();
      @(negedge CLK);
      chk_zero("rst_hold");
    end
    rst_b = 1'b1;
    sb_q.delete();
    for (int i = 0; i < DELAY; i++) sb_q.push_back('0);
    m_bc0_q = 1'b1;
    m_fb_q  = 1'b0;
`ifdef LDTU_ORBIT_CHECK_EN
    m_cnt   = '0;
    m_seen  = 1'b0;
    m_err   = 1'b0;
    m_edges = '0;
`endif
  endtask

  initial begin
    bus.bsl_limit = 7'd64;
    bus.DATA_in   = '0;
    bus.BC0_in    = 1'b0;
    bus.fallback  = 1'b0;
    apply_reset();

    // Threshold boundaries
    step(13'h003F, 1'b0, 1'b0);
    step(13'h0040, 1'b0, 1'b0);
    step(13'h1005, 1'b0, 1'b0);
    step(13'h0000, 1'b0, 1'b0);
    step(13'h1000, 1'b0, 1'b0);
    bus.bsl_limit = 7'd100;
    step(13'h003F, 1'b0, 1'b0);
    step(13'h0040, 1'b0, 1'b0);
    bus.bsl_limit = 7'd0;
    step(13'h0000, 1'b0, 1'b0);
    step(13'h0000, 1'b0, 1'b0);
    bus.bsl_limit = 7'd17;
    step(13'h0010, 1'b0, 1'b0);
    step(13'h0011, 1'b0, 1'b0);
    bus.bsl_limit = 7'd64;

    // BC0 level held for 5 cycles
    repeat (5) step(rnd_data(), 1'b1, 1'b0);
    repeat (4) step(rnd_data(), 1'b0, 1'b0);

    // Fallback routing, then toggle back between edges
    step(rnd_data(), 1'b1, 1'b1);
    repeat (9) step(rnd_data(), 1'b0, 1'b1);
    step(rnd_data(), 1'b1, 1'b1);
    repeat (4) step(rnd_data(), 1'b0, 1'b1);
    repeat (5) step(rnd_data(), 1'b0, 1'b0);
    step(rnd_data(), 1'b1, 1'b0);
    repeat (3) step(rnd_data(), 1'b0, 1'b0);

    // Back-to-back edges
    for (int k = 0; k < 8; k++) step(rnd_data(), (k % 2) == 0, 1'b0);

    // Random traffic including fallback toggles around pulses
    repeat (40) begin
      bus.bsl_limit = 7'($urandom_range(0, 127));
      step(rnd_data() & 13'h107F, rnd_bit(), rnd_bit());
    end
    bus.bsl_limit = 7'd64;

    // Reset mid-stream with BC0 high at release
    repeat (3) step(rnd_data(), 1'b1, 1'b0);
    apply_reset();
    step(13'h0001, 1'b1, 1'b0);
    step(13'h0002, 1'b1, 1'b0);
    step(13'h0003, 1'b0, 1'b0);
    step(13'h0004, 1'b1, 1'b0);
    repeat (3) step(13'h0005, 1'b0, 1'b0);

`ifdef LDTU_ORBIT_CHECK_EN
    apply_reset();
    step(rnd_data(), 1'b1, 1'b0);
    repeat (3) begin
      repeat (15) step(rnd_data(), 1'b0, 1'b0);
      step(rnd_data(), 1'b1, 1'b0);
    end
    repeat (14) step(rnd_data(), 1'b0, 1'b0);
    step(rnd_data(), 1'b1, 1'b0);
    repeat (15) step(rnd_data(), 1'b0, 1'b0);
    step(rnd_data(), 1'b1, 1'b0);
    repeat (4) step(rnd_data(), 1'b0, 1'b0);
    chk("orbit_err_sticky", 32'(bus.orbit_err), 32'd1);
    apply_reset();
    repeat (3) step(rnd_data(), 1'b0, 1'b0);
`endif

    repeat (DELAY) step('0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
